// File: rtl/sifh_zoom_window.sv
// sifh_zoom_window
//
// Purpose:
//    Multi-stage zoom-window generator for the SiFH dTOF histogrammer. The
//    block starts from the full TDC code range. After each histogram round it
//    takes the reported peak bin and builds a narrower window for the next
//    round. That window is two bins wide, centred on the peak bin, and
//    clamped to the code range. After NSTAGE refinements the final window is
//    handed downstream and a one-cycle done pulse is raised.
//
// Parameters:
//    NP     - TDC code width (window bound width)
//    NB     - bin index width, 2^NB bins per window, NB >= 2
//    NSTAGE - number of refinements; legal only if NP - NSTAGE*(NB-1) >= NB
//
// Ports:
//    clk        - clock, all state on rising edge
//    rst        - asynchronous active-high reset
//    start      - begin or restart a zoom sequence (overrides everything)
//    peak_ch    - peak bin index within the current window
//    peak_valid - peak_ch valid
//    peak_ready - block accepts peak_ch (only while waiting for a peak)
//    win_lo     - window lower bound (inclusive)
//    win_hi     - window upper bound (inclusive)
//    bin_shift  - log2 of the bin width of the presented window
//    stage      - refinement index of the presented window
//    win_valid  - window outputs valid
//    win_ready  - downstream accepts window
//    done       - one-cycle pulse when the final window is accepted
//    busy       - high whenever a sequence is in progress
module sifh_zoom_window #(
   parameter int NP     = 16,
   parameter int NB     = 4,
   parameter int NSTAGE = 4
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             start,
   input  logic [NB-1:0]                    peak_ch,
   input  logic                             peak_valid,
   output logic                             peak_ready,
   output logic [NP-1:0]                    win_lo,
   output logic [NP-1:0]                    win_hi,
   output logic [$clog2(NP+1)-1:0]          bin_shift,
   output logic [$clog2(NSTAGE+1)-1:0]      stage,
   output logic                             win_valid,
   input  logic                             win_ready,
   output logic                             done,
   output logic                             busy
);

   localparam int WSW = $clog2(NP + 1);
   localparam int STW = $clog2(NSTAGE + 1);
   localparam int AW  = NP + 2;

   // One past the top TDC code, in the extended arithmetic width.
   localparam logic [AW-1:0] FULL_RANGE = AW'(1) << NP;

   typedef enum logic [2:0] {
      IDLE,
      PRESENT,
      WAIT_PEAK,
      CALC,
      CLAMP
   } state_t;

   state_t             r_state;
   logic [NP-1:0]      r_base;
   logic [WSW-1:0]     r_ws;
   logic [NB-1:0]      r_peak;
   logic [AW-1:0]      r_rawLo;
   logic [NP-1:0]      r_winLo;
   logic [NP-1:0]      r_winHi;
   logic [WSW-1:0]     r_binShift;
   logic [STW-1:0]     r_stage;
   logic               r_winValid;
   logic               r_peakReady;
   logic               r_done;
   logic               r_busy;

   logic [WSW-1:0]     w_s;
   logic [AW-1:0]      w_peakShift;
   logic [AW-1:0]      w_halfBin;
   logic [AW-1:0]      w_rawLoNext;
   logic [AW-1:0]      w_wn;
   logic [AW-1:0]      w_rawEnd;
   logic [NP-1:0]      w_wnNp;
   logic [NP-1:0]      w_topLo;
   logic [NP-1:0]      w_loClamped;
   logic [NP-1:0]      w_hiClamped;
   logic [WSW-1:0]     w_newBinShift;

   // Bin width of the current window is 2^s. The unclamped lower bound of the
   // next window is the peak-bin centre minus one bin width. The arithmetic is
   // kept two bits wider than a TDC code, so the top bit acts as the sign and
   // the next bit catches overshoot past the top of the range.
   always_comb begin
      w_s           = r_ws - WSW'(NB);
      w_peakShift   = AW'(r_peak) << w_s;
      w_halfBin     = AW'(1) << (w_s - WSW'(1));
      w_rawLoNext   = AW'(r_base) + w_peakShift - w_halfBin;
      w_wn          = AW'(1) << (w_s + WSW'(1));
      w_rawEnd      = r_rawLo + w_wn;
      w_wnNp        = NP'(1) << (w_s + WSW'(1));
      w_topLo       = NP'(0) - w_wnNp;
      w_newBinShift = w_s + WSW'(1) - WSW'(NB);
   end

   // Clamp the new two-bin window into [0, 2^NP-1]. A negative raw bound pins
   // the window to zero. A window running past the top is slid down so that
   // it ends exactly at the last code.
   always_comb begin
      w_loClamped = r_rawLo[NP-1:0];
      if (r_rawLo[AW-1]) begin
         w_loClamped = '0;
      end else if (w_rawEnd > FULL_RANGE) begin
         w_loClamped = w_topLo;
      end
      w_hiClamped = w_loClamped + w_wnNp - NP'(1);
   end

   // Main sequencer. start has priority over every state and handshake.
   // PRESENT spends one cycle with the freshly loaded window before raising
   // win_valid. Because of this, win_valid follows start by one edge and
   // follows a peak handshake by three edges. Window outputs are loaded only
   // on start or in CLAMP, so they stay put across handshakes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_base      <= '0;
         r_ws        <= WSW'(NP);
         r_peak      <= '0;
         r_rawLo     <= '0;
         r_winLo     <= '0;
         r_winHi     <= '0;
         r_binShift  <= '0;
         r_stage     <= '0;
         r_winValid  <= 1'b0;
         r_peakReady <= 1'b0;
         r_done      <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (start) begin
            r_state     <= PRESENT;
            r_base      <= '0;
            r_ws        <= WSW'(NP);
            r_winLo     <= '0;
            r_winHi     <= '1;
            r_binShift  <= WSW'(NP - NB);
            r_stage     <= '0;
            r_winValid  <= 1'b0;
            r_peakReady <= 1'b0;
            r_busy      <= 1'b1;
         end else begin
            case (r_state)
               IDLE: begin
                  r_state <= IDLE;
               end
               PRESENT: begin
                  if (!r_winValid) begin
                     r_winValid <= 1'b1;
                  end else if (win_ready) begin
                     r_winValid <= 1'b0;
                     if (r_stage == STW'(NSTAGE)) begin
                        r_state <= IDLE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                     end else begin
                        r_state     <= WAIT_PEAK;
                        r_peakReady <= 1'b1;
                     end
                  end
               end
               WAIT_PEAK: begin
                  if (peak_valid) begin
                     r_peak      <= peak_ch;
                     r_peakReady <= 1'b0;
                     r_state     <= CALC;
                  end
               end
               CALC: begin
                  r_rawLo <= w_rawLoNext;
                  r_state <= CLAMP;
               end
               CLAMP: begin
                  r_base     <= w_loClamped;
                  r_ws       <= w_s + WSW'(1);
                  r_stage    <= r_stage + STW'(1);
                  r_winLo    <= w_loClamped;
                  r_winHi    <= w_hiClamped;
                  r_binShift <= w_newBinShift;
                  r_state    <= PRESENT;
               end
               default: begin
                  r_state <= IDLE;
               end
            endcase
         end
      end
   end

   assign peak_ready = r_peakReady;
   assign win_lo     = r_winLo;
   assign win_hi     = r_winHi;
   assign bin_shift  = r_binShift;
   assign stage      = r_stage;
   assign win_valid  = r_winValid;
   assign done       = r_done;
   assign busy       = r_busy;

endmodule

// File: tb/tb_sifh_zoom_window.sv
// tb_sifh_zoom_window
//
// Self-checking bench for sifh_zoom_window with NP=16, NB=4, NSTAGE=4.
// The reference model tracks the current window as a plain integer base and
// width. Each new window is worked out from the peak bin with ordinary
// integer arithmetic: centre of the peak bin minus one bin width, two bins
// wide, clamped into 0..65535.
module tb_sifh_zoom_window;

   localparam int NP     = 16;
   localparam int NB     = 4;
   localparam int NSTAGE = 4;
   localparam int RANGE  = 1 << NP;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic [NB-1:0] peak_ch = '0;
   logic          peak_valid = 1'b0;
   logic          peak_ready;
   logic [NP-1:0] win_lo;
   logic [NP-1:0] win_hi;
   logic [4:0]    bin_shift;
   logic [2:0]    stage;
   logic          win_valid;
   logic          win_ready = 1'b0;
   logic          done;
   logic          busy;

   int total = 0;
   int bad   = 0;

   // Reference model of the current window.
   int mBase;
   int mWidth;
   int mStage;

   sifh_zoom_window #(.NP(NP), .NB(NB), .NSTAGE(NSTAGE)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .peak_ch    (peak_ch),
      .peak_valid (peak_valid),
      .peak_ready (peak_ready),
      .win_lo     (win_lo),
      .win_hi     (win_hi),
      .bin_shift  (bin_shift),
      .stage      (stage),
      .win_valid  (win_valid),
      .win_ready  (win_ready),
      .done       (done),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   function automatic int log2Int(input int v);
      int r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   task automatic modelReset();
      mBase  = 0;
      mWidth = RANGE;
      mStage = 0;
   endtask

   // Next window from a peak bin, straight from the zoom rule.
   task automatic modelPeak(input int p);
      int bw, raw, wn, lo;
      bw  = mWidth / (1 << NB);
      raw = mBase + p * bw + bw / 2 - bw;
      wn  = 2 * bw;
      if (raw < 0) lo = 0;
      else if (raw + wn > RANGE) lo = RANGE - wn;
      else lo = raw;
      mBase  = lo;
      mWidth = wn;
      mStage = mStage + 1;
   endtask

   task automatic checkWindow(input string tag);
      checkOutput({tag, "_valid"}, 32'(win_valid), 32'd1);
      checkOutput({tag, "_lo"}, 32'(win_lo), 32'(mBase));
      checkOutput({tag, "_hi"}, 32'(win_hi), 32'(mBase + mWidth - 1));
      checkOutput({tag, "_shift"}, 32'(bin_shift), 32'(log2Int(mWidth) - NB));
      checkOutput({tag, "_stage"}, 32'(stage), 32'(mStage));
   endtask

   // Pulse start and expect the full-range window one edge later.
   task automatic applyStimulus_start(input string tag);
      start = 1'b1;
      tick();
      start = 1'b0;
      modelReset();
      tick();
      checkWindow(tag);
      checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
      checkOutput({tag, "_pready"}, 32'(peak_ready), 32'd0);
   endtask

   // Hold win_ready low for hold cycles, checking the window stays put, then accept it.
   task automatic applyStimulus_accept(input string tag, input int hold);
      bit isFinal;
      isFinal = (mStage == NSTAGE);
      win_ready = 1'b0;
      for (int i = 0; i < hold; i++) begin
         tick();
         checkOutput({tag, "_holdValid"}, 32'(win_valid), 32'd1);
         checkOutput({tag, "_holdLo"}, 32'(win_lo), 32'(mBase));
         checkOutput({tag, "_holdHi"}, 32'(win_hi), 32'(mBase + mWidth - 1));
      end
      win_ready = 1'b1;
      tick();
      win_ready = 1'b0;
      checkOutput({tag, "_validDrop"}, 32'(win_valid), 32'd0);
      checkOutput({tag, "_done"}, 32'(done), 32'(isFinal));
      checkOutput({tag, "_busyAfter"}, 32'(busy), 32'(!isFinal));
      checkOutput({tag, "_pready"}, 32'(peak_ready), 32'(!isFinal));
      checkOutput({tag, "_loKept"}, 32'(win_lo), 32'(mBase));
      if (isFinal) begin
         tick();
         checkOutput({tag, "_donePulse"}, 32'(done), 32'd0);
         checkOutput({tag, "_idleValid"}, 32'(win_valid), 32'd0);
      end
   endtask

   // Hand over a peak and expect the refined window three edges after the handshake.
   task automatic applyStimulus_peak(input string tag, input int p);
      peak_ch    = NB'(p);
      peak_valid = 1'b1;
      tick();
      peak_valid = 1'b0;
      checkOutput({tag, "_preadyDrop"}, 32'(peak_ready), 32'd0);
      modelPeak(p);
      tick();
      tick();
      checkOutput({tag, "_notYet"}, 32'(win_valid), 32'd0);
      tick();
      checkWindow(tag);
   endtask

   initial begin
      int p;
      int hold;

      // Reset state.
      rst = 1'b1;
      #12;
      checkOutput("rst_valid", 32'(win_valid), 32'd0);
      checkOutput("rst_lo", 32'(win_lo), 32'd0);
      checkOutput("rst_hi", 32'(win_hi), 32'd0);
      checkOutput("rst_shift", 32'(bin_shift), 32'd0);
      checkOutput("rst_stage", 32'(stage), 32'd0);
      checkOutput("rst_pready", 32'(peak_ready), 32'd0);
      checkOutput("rst_done", 32'(done), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      tick();

      // Initial window and nominal refinement (5 then 0).
      applyStimulus_start("init");
      checkOutput("init_hiConst", 32'(win_hi), 32'd65535);
      checkOutput("init_shiftConst", 32'(bin_shift), 32'd12);
      applyStimulus_accept("nom0", 0);
      applyStimulus_peak("nom1", 5);
      checkOutput("nom1_loConst", 32'(win_lo), 32'd18432);
      checkOutput("nom1_hiConst", 32'(win_hi), 32'd26623);
      checkOutput("nom1_shiftConst", 32'(bin_shift), 32'd9);
      applyStimulus_accept("nom1", 0);
      applyStimulus_peak("nom2", 0);
      checkOutput("nom2_loConst", 32'(win_lo), 32'd18176);
      checkOutput("nom2_hiConst", 32'(win_hi), 32'd19199);
      checkOutput("nom2_shiftConst", 32'(bin_shift), 32'd6);

      // Low clamp from the initial window.
      applyStimulus_start("lowStart");
      applyStimulus_accept("low0", 0);
      applyStimulus_peak("low1", 0);
      checkOutput("low_loConst", 32'(win_lo), 32'd0);
      checkOutput("low_hiConst", 32'(win_hi), 32'd8191);

      // High clamp from the initial window.
      applyStimulus_start("highStart");
      applyStimulus_accept("high0", 0);
      applyStimulus_peak("high1", 15);
      checkOutput("high_loConst", 32'(win_lo), 32'd57344);
      checkOutput("high_hiConst", 32'(win_hi), 32'd65535);

      // Full run with three cycles of backpressure on every window.
      applyStimulus_start("fullStart");
      applyStimulus_accept("full0", 3);
      applyStimulus_peak("full1", 7);
      applyStimulus_accept("full1", 3);
      applyStimulus_peak("full2", 12);
      applyStimulus_accept("full2", 3);
      applyStimulus_peak("full3", 2);
      applyStimulus_accept("full3", 3);
      applyStimulus_peak("full4", 9);
      checkOutput("full4_shiftConst", 32'(bin_shift), 32'd0);
      checkOutput("full4_width", 32'(win_hi) - 32'(win_lo) + 32'd1, 32'd16);
      applyStimulus_accept("full4", 3);

      // Abort during CALC with peak_valid still high: restart, no done.
      applyStimulus_start("abortStart");
      applyStimulus_accept("abort0", 0);
      peak_ch    = 4'd11;
      peak_valid = 1'b1;
      tick();
      start = 1'b1;
      tick();
      start      = 1'b0;
      peak_valid = 1'b0;
      modelReset();
      checkOutput("abort_done0", 32'(done), 32'd0);
      tick();
      checkWindow("abort");
      checkOutput("abort_done1", 32'(done), 32'd0);
      checkOutput("abort_pready", 32'(peak_ready), 32'd0);

      // Async reset while a window is presented clears outputs before the next edge.
      rst = 1'b1;
      #2;
      checkOutput("arst_valid", 32'(win_valid), 32'd0);
      checkOutput("arst_hi", 32'(win_hi), 32'd0);
      checkOutput("arst_shift", 32'(bin_shift), 32'd0);
      checkOutput("arst_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      tick();

      // Randomized full sequences with random peaks and backpressure.
      for (int r = 0; r < 12; r++) begin
         applyStimulus_start("rndStart");
         for (int k = 0; k < NSTAGE; k++) begin
            hold = int'($urandom_range(0, 3));
            applyStimulus_accept("rndAcc", hold);
            p = int'($urandom_range(0, 15));
            applyStimulus_peak("rndPeak", p);
         end
         hold = int'($urandom_range(0, 3));
         applyStimulus_accept("rndFinal", hold);
         checkOutput("rnd_idleBusy", 32'(busy), 32'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sifh_zoom_window.md
Name: sifh_zoom_window

Overview:
- Sequential multi-stage zoom-window generator for the SiFH dTOF histogrammer.
- Each histogram round reports a peak bin index within the current window. The block then computes a narrower, clamped TDC-code window centred on that bin for the next round.
- Iterates for NSTAGE refinements, then flags done.
- Sits between the peak finder (upstream) and the histogram window/bin-shift registers (downstream), with valid/ready handshakes on both sides.

Parameters:
- NP, 16: TDC code width (window bound width).
- NB, 4: bin index width; 2^NB bins per window; NB>=2.
- NSTAGE, 4: number of refinements. Legal only if NP - NSTAGE*(NB-1) >= NB.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin or restart a zoom sequence.
- peak_ch  in  NB  peak bin index within the current window.
- peak_valid  in  1  peak_ch valid.
- peak_ready  out  1  block accepts peak_ch.
- win_lo  out  NP  window lower bound (inclusive).
- win_hi  out  NP  window upper bound (inclusive).
- bin_shift  out  clog2(NP+1)  log2 of bin width of the presented window.
- stage  out  clog2(NSTAGE+1)  refinement index of the presented window.
- win_valid  out  1  window outputs valid.
- win_ready  in  1  downstream accepts window.
- done  out  1  one-cycle pulse when the final window is accepted.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset (async, active-high): state=IDLE. All outputs 0. Internal base=0, ws=NP, stage=0.
- Internal state:
  - base (NP bits): current window lower bound.
  - ws: log2 of current window width.
  - Bin width = 2^s, where s = ws-NB.
- FSM states:
  - IDLE: wait for start.
  - PRESENT: win_valid=1; hold until win_ready.
  - WAIT_PEAK: peak_ready=1.
  - CALC: compute raw bounds.
  - CLAMP: clamp and register outputs.
- IDLE --start--> PRESENT.
  - Initial window: win_lo=0, win_hi=2^NP-1, bin_shift=NP-NB, stage=0.
  - win_valid rises at the edge after start is sampled.
- PRESENT --win_valid&win_ready--> one of:
  - WAIT_PEAK, if stage<NSTAGE.
  - IDLE with done=1 for one cycle, if stage==NSTAGE.
- WAIT_PEAK --peak_valid&peak_ready--> CALC. peak_ch is sampled only on this handshake.
- CALC, in signed NP+2-bit arithmetic:
  - raw_lo = base + (peak_ch<<s) - 2^(s-1).
  - That is: peak-bin centre minus one bin width.
- CLAMP: new width Wn = 2^(s+1), i.e. two bins.
  - If raw_lo<0: lo=0.
  - Else if raw_lo+Wn-1 > 2^NP-1: lo = 2^NP-Wn.
  - Else: lo=raw_lo.
  - hi = lo+Wn-1.
  - Update: base<=lo; ws<=s+1; stage<=stage+1.
  - Register outputs: win_lo, win_hi, bin_shift=s+1-NB, stage.
  - Next state PRESENT.
- Latency: peak handshake at edge e → win_valid high from edge e+3 (CALC e+1, CLAMP e+2, PRESENT e+3).
- Window outputs hold stable while win_valid&!win_ready. They also hold after handshake until the next CLAMP or start.
- win_valid is deasserted outside PRESENT.
- start in any state (including CALC/CLAMP/PRESENT) aborts the sequence and restarts at the initial window. start has priority over any same-cycle handshake; a simultaneous peak or window handshake is ignored.
- No done pulse on abort.
- peak_ready is 0 in all states except WAIT_PEAK.
- Async rst mid-sequence returns to the reset values immediately.

Test Plan (NP=16, NB=4, NSTAGE=4):
- Start: rst, then start → win_valid next edge; win_lo=0, win_hi=65535, bin_shift=12, stage=0.
- Nominal refinement:
  - Accept window, peak_ch=5 → after 3 cycles win_lo=18432, win_hi=26623, bin_shift=9, stage=1.
  - Then peak_ch=0 → win_lo=18176, win_hi=19199, bin_shift=6, stage=2.
- Low clamp: from initial window, peak_ch=0 → win_lo=0, win_hi=8191.
- High clamp: from initial window, peak_ch=15 → win_lo=57344, win_hi=65535.
- Full run with backpressure:
  - Four peaks complete the sequence: stage 4 window has bin_shift=0 and width 16; done pulses once on its handshake; return to IDLE, busy=0.
  - Hold win_ready low 3 cycles on every window → outputs stable, win_valid held.
- Abort: start asserted during CALC, with peak_valid high in that cycle → restart window 0..65535, stage=0, no done pulse. Async rst mid-PRESENT → all outputs 0 immediately.
